// File: rtl/mask_hit_pkg.sv
// ---------------------------------------------------------------------------
// mask_hit_pkg
//   Shared definitions for the mask hit counter: FSM state encoding and the
//   widths of the ones accumulator and hit counter.
// ---------------------------------------------------------------------------
package mask_hit_pkg;

   // A 256-sample window of 0xFF reaches 2048 ones, which needs 12 bits.
   localparam int ONES_W = 12;

   // A 256-sample window can hit 256 times, which needs 9 bits.
   localparam int HIT_W  = 9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      REPORT = 2'd2
   } state_t;

endpackage

// File: rtl/popcount8.sv
// ---------------------------------------------------------------------------
// popcount8
//   Combinational count of the set bits in one byte.
//
//   Ports
//     i_data  [7:0]  byte to count
//     o_count [3:0]  number of ones in i_data (0..8)
// ---------------------------------------------------------------------------
module popcount8 (
   input  logic [7:0] i_data,
   output logic [3:0] o_count
);

   always_comb begin
      o_count = 4'd0;
      for (int i = 0; i < 8; i++) begin
         o_count = o_count + {3'b000, i_data[i]};
      end
   end

endmodule

// File: rtl/mask_hit_counter.sv
// ---------------------------------------------------------------------------
// mask_hit_counter
//   Counts, over a window of masked byte samples, how many samples were
//   non-zero (hits) and how many bits were set in total (ones), then reports
//   the result as three bytes over a valid/ready handshake:
//     B0 = min(hits, 255)
//     B1 = ones[7:0]
//     B2 = {hits == 256, 3'b000, ones[11:8]}
//
//   Parameters
//     WIN_W       width of window_len; window_len == 0 means 2**WIN_W samples
//
//   Ports
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     ena         sample enable (does not gate the report handshake)
//     in_data     masked sample byte
//     in_valid    in_data carries a sample this cycle
//     start       one-cycle pulse that opens a window (honoured only in IDLE)
//     window_len  samples per window, captured on start
//     out_data    registered report byte, zero when out_valid is low
//     out_valid   out_data holds a report byte
//     out_ready   consumer accepts out_data
//     busy        FSM is not in IDLE
// ---------------------------------------------------------------------------
module mask_hit_counter
   import mask_hit_pkg::*;
#(
   parameter int WIN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             start,
   input  logic [WIN_W-1:0] window_len,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   state_t              r_state;
   logic [WIN_W-1:0]    r_len;
   logic [WIN_W:0]      r_cnt;
   logic [HIT_W-1:0]    r_hits;
   logic [ONES_W-1:0]   r_ones;
   logic [1:0]          r_idx;
   logic [7:0]          r_out_data;
   logic                r_out_valid;

   logic [3:0]          w_pop;
   logic                w_take;
   logic                w_last;
   logic [WIN_W:0]      w_cnt_nxt;
   logic [WIN_W:0]      w_len_full;
   logic [HIT_W-1:0]    w_hits_nxt;
   logic [ONES_W-1:0]   w_ones_nxt;
   logic [1:0]          w_idx_nxt;

   // Hit count saturated into one byte; only a full 256-hit window clips.
   function automatic logic [7:0] sat_hits(input logic [HIT_W-1:0] hits);
      return (hits > HIT_W'(255)) ? 8'hFF : hits[7:0];
   endfunction

   function automatic logic [7:0] report_byte(
      input logic [1:0]        idx,
      input logic [HIT_W-1:0]  hits,
      input logic [ONES_W-1:0] ones
   );
      logic [7:0] b;
      case (idx)
         2'd0:    b = sat_hits(hits);
         2'd1:    b = ones[7:0];
         default: b = {(hits == HIT_W'(256)), 3'b000, ones[ONES_W-1:8]};
      endcase
      return b;
   endfunction

   popcount8 u_popcount (
      .i_data  (in_data),
      .o_count (w_pop)
   );

   assign w_take     = (r_state == COUNT) && in_valid && ena;
   assign w_cnt_nxt  = r_cnt + {{WIN_W{1'b0}}, 1'b1};
   // A zero length extends to 2**WIN_W by setting the carry bit.
   assign w_len_full = {(r_len == '0), r_len};
   assign w_last     = w_take && (w_cnt_nxt == w_len_full);
   assign w_hits_nxt = r_hits + {{(HIT_W-1){1'b0}}, (in_data != 8'd0)};
   assign w_ones_nxt = r_ones + {{(ONES_W-4){1'b0}}, w_pop};
   assign w_idx_nxt  = r_idx + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_cnt       <= '0;
         r_hits      <= '0;
         r_ones      <= '0;
         r_idx       <= 2'd0;
         r_out_data  <= 8'd0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_len   <= window_len;
                  r_cnt   <= '0;
                  r_hits  <= '0;
                  r_ones  <= '0;
                  r_idx   <= 2'd0;
                  r_state <= COUNT;
               end
            end

            COUNT: begin
               if (w_take) begin
                  r_cnt  <= w_cnt_nxt;
                  r_hits <= w_hits_nxt;
                  r_ones <= w_ones_nxt;
                  // B0 is built from the post-sample totals so it is ready
                  // the cycle right after the last sample.
                  if (w_last) begin
                     r_state     <= REPORT;
                     r_idx       <= 2'd0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= report_byte(2'd0, w_hits_nxt, w_ones_nxt);
                  end
               end
            end

            REPORT: begin
               if (out_ready) begin
                  if (r_idx == 2'd2) begin
                     r_state     <= IDLE;
                     r_idx       <= 2'd0;
                     r_out_valid <= 1'b0;
                     r_out_data  <= 8'd0;
                  end else begin
                     r_idx      <= w_idx_nxt;
                     r_out_data <= report_byte(w_idx_nxt, r_hits, r_ones);
                  end
               end
            end

            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_out_data  <= 8'd0;
            end
         endcase
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mask_hit_counter.sv
// ---------------------------------------------------------------------------
// tb_mask_hit_counter
//   Self-checking bench for mask_hit_counter: a table of windows with
//   hand-computed report bytes, plus directed sequences for back-pressure,
//   enable gating, ignored starts and reset mid-window.
// ---------------------------------------------------------------------------
module tb_mask_hit_counter;

   localparam int WIN_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ena;
   logic [7:0]       in_data;
   logic             in_valid;
   logic             start;
   logic [WIN_W-1:0] window_len;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   always #5 clk = ~clk;

   mask_hit_counter #(.WIN_W(WIN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .start      (start),
      .window_len (window_len),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   typedef struct {
      logic [7:0]      len;
      int              n;
      logic [3:0][7:0] pat;
      logic [7:0]      e0;
      logic [7:0]      e1;
      logic [7:0]      e2;
      bit              gaps;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'd0;
   vec_t       vecs[7];

   function automatic vec_t mk(input logic [7:0] len, input int n,
                               input logic [7:0] p0, input logic [7:0] p1,
                               input logic [7:0] p2, input logic [7:0] p3,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input bit gaps);
      vec_t v;
      v.len = len; v.n = n;
      v.pat[0] = p0; v.pat[1] = p1; v.pat[2] = p2; v.pat[3] = p3;
      v.e0 = e0; v.e1 = e1; v.e2 = e2; v.gaps = gaps;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Runs mid-cycle: scoreboard pops on every accepted byte.
   task automatic monitor();
      logic [7:0] e;
      if (prev_stall) begin
         check("hold_valid", 32'(out_valid), 32'(1));
         check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (!out_valid) check("idle_data_zero", 32'(out_data), 32'(0));
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", out_data);
         end else begin
            e = exp_q.pop_front();
            check("report_byte", 32'(out_data), 32'(e));
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit rand_rdy);
      int k = 0;
      while (exp_q.size() != 0 && k < 600) begin
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         k++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d bytes left required=0", exp_q.size());
         exp_q.delete();
      end
      out_ready = 1'b1;
      check("busy_after_drain", 32'(busy), 32'(0));
   endtask

   task automatic run_window(input vec_t v);
      window_len = v.len;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'(1));
      exp_q.push_back(v.e0);
      exp_q.push_back(v.e1);
      exp_q.push_back(v.e2);
      for (int i = 0; i < v.n; i++) begin
         // Filler cycles carry 0xFF so a wrongly counted one shows up.
         if (v.gaps && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               in_valid = 1'b0; ena = 1'b1;
            end else begin
               in_valid = 1'b1; ena = 1'b0;
            end
            in_data = 8'hFF;
            tick();
         end
         in_valid = 1'b1;
         ena      = 1'b1;
         in_data  = v.pat[i % 4];
         tick();
      end
      in_valid = 1'b0;
      in_data  = 8'd0;
      check("b0_latency", 32'(out_valid), 32'(1));
      drain(v.gaps);
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b0; in_data = 8'd0; in_valid = 1'b0;
      start = 1'b0; window_len = '0; out_ready = 1'b1;
      #1;
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_out_valid", 32'(out_valid), 32'(0));
      check("reset_out_data", 32'(out_data), 32'(0));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      //             len    n    p0     p1     p2     p3     B0     B1     B2    gaps
      vecs[0] = mk(8'd4,   4,   8'hFF, 8'h00, 8'h0F, 8'h01, 8'h03, 8'h0D, 8'h00, 1'b0);
      vecs[1] = mk(8'd0,   256, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h88, 1'b0);
      vecs[2] = mk(8'd1,   1,   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      vecs[3] = mk(8'd8,   8,   8'h80, 8'h03, 8'h00, 8'hAA, 8'h06, 8'h0E, 8'h00, 1'b1);
      vecs[4] = mk(8'd255, 255, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'h07, 1'b1);
      vecs[5] = mk(8'd0,   256, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 1'b1);
      vecs[6] = mk(8'd2,   2,   8'h80, 8'h03, 8'h80, 8'h03, 8'h02, 8'h03, 8'h00, 1'b1);

      for (int t = 0; t < 7; t++) run_window(vecs[t]);

      // Back-pressure: B0 must sit still for five stalled cycles.
      window_len = 8'd2; start = 1'b1; out_ready = 1'b0;
      tick();
      start = 1'b0;
      exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
      in_valid = 1'b1; ena = 1'b1; in_data = 8'h80; tick();
      in_data = 8'h03; tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(out_valid), 32'(1));
         check("stall_b0", 32'(out_data), 32'(8'h02));
         tick();
      end
      drain(1'b0);

      // Enable toggling: only the three ena-high cycles are samples; the
      // report then drains with ena held low.
      window_len = 8'd3; start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1; in_data = 8'h01;
      exp_q.push_back(8'h03); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
      for (int i = 0; i < 5; i++) begin
         ena = (i % 2 == 0);
         if (i == 4) check("ena_not_early", 32'(out_valid), 32'(0));
         tick();
      end
      in_valid = 1'b0; ena = 1'b0;
      check("ena_b0_latency", 32'(out_valid), 32'(1));
      drain(1'b0);
      ena = 1'b1;

      // Starts and length changes inside a window are ignored.
      window_len = 8'd3; start = 1'b1;
      tick();
      exp_q.push_back(8'h03); exp_q.push_back(8'h04); exp_q.push_back(8'h00);
      window_len = 8'd1; start = 1'b1; in_valid = 1'b1; in_data = 8'h01;
      tick();
      start = 1'b0; in_data = 8'h02;
      tick();
      check("len_change_ignored", 32'(out_valid), 32'(0));
      in_data = 8'h03;
      tick();
      in_valid = 1'b0; out_ready = 1'b0; start = 1'b1; window_len = 8'd5;
      tick();
      start = 1'b0;
      check("start_in_report_busy", 32'(busy), 32'(1));
      drain(1'b0);
      // Start in the cycle right after B2 is accepted.
      run_window(mk(8'd1, 1, 8'h81, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 1'b0));

      // Reset mid-window discards the partial counts.
      window_len = 8'd5; start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1; ena = 1'b1; in_data = 8'hFF;
      tick();
      tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", 32'(busy), 32'(0));
      check("async_rst_valid", 32'(out_valid), 32'(0));
      check("async_rst_data", 32'(out_data), 32'(0));
      tick();
      rst_n = 1'b1;
      prev_stall = 1'b0;
      tick();
      run_window(mk(8'd1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));

      repeat (4) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
